// File: rtl/sent_rx_fast_fifo.sv
// Receive-side FIFO for decoded SENT fast-channel words.
// Holds pushed words in order until they are popped, and reports occupancy and sticky error flags.
module sent_rx_fast_fifo #(
    parameter int DATA_WIDTH  = 12,
    parameter int ADDR_WIDTH  = 5,
    parameter int AFULL_LEVEL = 28
) (
    input  logic                  clk_rx,
    input  logic                  reset_rx,
    input  logic                  write_enable_rx_i,
    input  logic [DATA_WIDTH-1:0] data_fast_i,
    input  logic                  read_enable_rx_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] data_rx_o,
    output logic                  data_valid_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra bit so that full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   wr_ptr_reg;
    logic [ADDR_WIDTH:0]   rd_ptr_reg;
    logic [DATA_WIDTH-1:0] data_rx_reg;
    logic                  data_valid_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic [ADDR_WIDTH:0]   level_next;
    logic                  pop_accept;
    logic                  push_accept;

    always_comb begin
        level_next  = wr_ptr_reg - rd_ptr_reg;
        pop_accept  = read_enable_rx_i && (level_next != '0);
        // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
        push_accept = write_enable_rx_i && ((level_next != DEPTH_LVL) || pop_accept);
    end

    always_ff @(posedge clk_rx) begin
        if (push_accept && !clear_i) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= data_fast_i;
        end
    end

    always_ff @(posedge clk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            data_rx_reg    <= '0;
            data_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            data_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            data_valid_reg <= pop_accept;
            if (pop_accept) begin
                data_rx_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
                rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
            end
            if (push_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (read_enable_rx_i && !pop_accept) begin
                underflow_reg <= 1'b1;
            end
            if (write_enable_rx_i && !push_accept) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign data_rx_o     = data_rx_reg;
    assign data_valid_o  = data_valid_reg;
    assign level_o       = level_next;
    assign empty_o       = (level_next == '0);
    assign full_o        = (level_next == DEPTH_LVL);
    assign almost_full_o = (level_next >= AFULL_LVL);
    assign overflow_o    = overflow_reg;
    assign underflow_o   = underflow_reg;

endmodule

// File: tb/tb_sent_rx_fast_fifo.sv
// Randomised and directed checks of sent_rx_fast_fifo against a queue-based reference model.
module tb_sent_rx_fast_fifo;

    logic        clk_rx = 1'b0;
    logic        reset_rx;
    logic        write_enable_rx_i;
    logic [11:0] data_fast_i;
    logic        read_enable_rx_i;
    logic        clear_i;
    logic [11:0] data_rx_o;
    logic        data_valid_o;
    logic        empty_o;
    logic        full_o;
    logic        almost_full_o;
    logic [5:0]  level_o;
    logic        overflow_o;
    logic        underflow_o;

    sent_rx_fast_fifo dut (
        .clk_rx            (clk_rx),
        .reset_rx          (reset_rx),
        .write_enable_rx_i (write_enable_rx_i),
        .data_fast_i       (data_fast_i),
        .read_enable_rx_i  (read_enable_rx_i),
        .clear_i           (clear_i),
        .data_rx_o         (data_rx_o),
        .data_valid_o      (data_valid_o),
        .empty_o           (empty_o),
        .full_o            (full_o),
        .almost_full_o     (almost_full_o),
        .level_o           (level_o),
        .overflow_o        (overflow_o),
        .underflow_o       (underflow_o)
    );

    always #5 clk_rx = ~clk_rx;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          model_q[$];
    logic [11:0] model_data;
    logic        model_valid;
    logic        model_ovf;
    logic        model_unf;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_data  = '0;
        model_valid = 1'b0;
        model_ovf   = 1'b0;
        model_unf   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},  {20'd0, data_rx_o}, {20'd0, model_data});
        check({tag, ".valid"}, {31'd0, data_valid_o}, {31'd0, model_valid});
        check({tag, ".level"}, {26'd0, level_o}, model_q.size());
        check({tag, ".empty"}, {31'd0, empty_o}, {31'd0, model_q.size() == 0});
        check({tag, ".full"},  {31'd0, full_o}, {31'd0, model_q.size() == 32});
        check({tag, ".afull"}, {31'd0, almost_full_o}, {31'd0, model_q.size() >= 28});
        check({tag, ".ovf"},   {31'd0, overflow_o}, {31'd0, model_ovf});
        check({tag, ".unf"},   {31'd0, underflow_o}, {31'd0, model_unf});
    endtask

    // One clock: apply inputs, advance the model by the FIFO rules, compare after the edge.
    task automatic step(input logic we, input logic [11:0] d, input logic re, input logic clr,
                        input string tag);
        bit pop_ok;
        bit push_ok;
        write_enable_rx_i = we;
        data_fast_i       = d;
        read_enable_rx_i  = re;
        clear_i           = clr;
        @(posedge clk_rx);
        #1;
        if (clr) begin
            model_q.delete();
            model_valid = 1'b0;
            model_ovf   = 1'b0;
            model_unf   = 1'b0;
        end else begin
            pop_ok  = re && (model_q.size() > 0);
            push_ok = we && ((model_q.size() < 32) || pop_ok);
            if (re && !pop_ok) model_unf = 1'b1;
            if (we && !push_ok) model_ovf = 1'b1;
            model_valid = pop_ok;
            if (pop_ok) model_data = 12'(model_q.pop_front());
            if (push_ok) model_q.push_back(int'(d));
        end
        $display("cyc we=%0d d=%03h re=%0d clr=%0d -> data=%03h v=%0d lvl=%0d ovf=%0d unf=%0d [%s]",
                 we, d, re, clr, data_rx_o, data_valid_o, level_o, overflow_o, underflow_o, tag);
        check_all(tag);
    endtask

    initial begin
        reset_rx          = 1'b1;
        write_enable_rx_i = 1'b0;
        data_fast_i       = '0;
        read_enable_rx_i  = 1'b0;
        clear_i           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_rx);
        #1;
        // T1 reset state
        check_all("t1_reset");
        check("t1_data_zero", {20'd0, data_rx_o}, 32'h0);
        reset_rx = 1'b0;

        // T2 ordering
        step(1'b1, 12'h123, 1'b0, 1'b0, "t2_push");
        step(1'b1, 12'h456, 1'b0, 1'b0, "t2_push");
        step(1'b1, 12'h789, 1'b0, 1'b0, "t2_push");
        step(1'b0, 12'h000, 1'b1, 1'b0, "t2_pop");
        check("t2_first", {20'd0, data_rx_o}, 32'h123);
        step(1'b0, 12'h000, 1'b1, 1'b0, "t2_pop");
        step(1'b0, 12'h000, 1'b1, 1'b0, "t2_pop");
        check("t2_third", {20'd0, data_rx_o}, 32'h789);
        step(1'b0, 12'h000, 1'b0, 1'b0, "t2_idle");
        check("t2_valid_drop", {31'd0, data_valid_o}, 32'h0);

        // T3 fill to full, then overflow
        for (int i = 0; i < 32; i++) step(1'b1, 12'(i), 1'b0, 1'b0, "t3_fill");
        check("t3_full", {31'd0, full_o}, 32'h1);
        step(1'b1, 12'hABC, 1'b0, 1'b0, "t3_over");
        check("t3_ovf", {31'd0, overflow_o}, 32'h1);
        step(1'b0, 12'h000, 1'b1, 1'b0, "t3_pop");
        check("t3_pop0", {20'd0, data_rx_o}, 32'h000);
        for (int i = 0; i < 31; i++) step(1'b0, 12'h000, 1'b1, 1'b0, "t3_drain");

        // T4 wrap: pointers are already advanced, so they cross the wrap here
        for (int i = 0; i < 40; i++) step(1'b1, 12'(12'h100 + i), (i > 0), 1'b0, "t4_pair");
        step(1'b0, 12'h000, 1'b1, 1'b0, "t4_last");
        check("t4_last_word", {20'd0, data_rx_o}, 32'h127);

        // T5 simultaneous push+pop at full and at empty
        for (int i = 0; i < 32; i++) step(1'b1, 12'(12'h200 + i), 1'b0, 1'b0, "t5_fill");
        step(1'b0, 12'h000, 1'b0, 1'b1, "t5_clrflags");
        for (int i = 0; i < 32; i++) step(1'b1, 12'(12'h200 + i), 1'b0, 1'b0, "t5_refill");
        step(1'b1, 12'h5A5, 1'b1, 1'b0, "t5_full_pp");
        check("t5_full_level", {26'd0, level_o}, 32'd32);
        check("t5_no_ovf", {31'd0, overflow_o}, 32'h0);
        for (int i = 0; i < 32; i++) step(1'b0, 12'h000, 1'b1, 1'b0, "t5_drain");
        check("t5_last_5a5", {20'd0, data_rx_o}, 32'h5A5);
        step(1'b1, 12'h3C3, 1'b1, 1'b0, "t5_empty_pp");
        check("t5_unf", {31'd0, underflow_o}, 32'h1);
        check("t5_nofall", {31'd0, data_valid_o}, 32'h0);
        step(1'b0, 12'h000, 1'b1, 1'b0, "t5_pop");
        check("t5_3c3", {20'd0, data_rx_o}, 32'h3C3);

        // T6 flush with concurrent push/pop
        for (int i = 0; i < 10; i++) step(1'b1, 12'(12'h300 + i), 1'b0, 1'b0, "t6_fill");
        step(1'b1, 12'hEEE, 1'b1, 1'b1, "t6_clear");
        check("t6_level0", {26'd0, level_o}, 32'd0);
        check("t6_unf0", {31'd0, underflow_o}, 32'h0);
        step(1'b1, 12'h777, 1'b0, 1'b0, "t6_push");
        step(1'b0, 12'h000, 1'b1, 1'b0, "t6_pop");
        check("t6_777", {20'd0, data_rx_o}, 32'h777);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 60) == 0), "rand");
        end

        // Asynchronous reset mid-burst takes effect between edges
        for (int i = 0; i < 5; i++) step(1'b1, 12'(12'h400 + i), (i > 2), 1'b0, "burst");
        write_enable_rx_i = 1'b1;
        data_fast_i       = 12'h4FF;
        #2;
        reset_rx = 1'b1;
        #1;
        model_reset();
        check_all("t6_async_rst");
        @(negedge clk_rx);
        reset_rx = 1'b0;
        step(1'b1, 12'h9A1, 1'b0, 1'b0, "post_rst_push");
        step(1'b1, 12'h9A2, 1'b0, 1'b0, "post_rst_push");
        step(1'b0, 12'h000, 1'b1, 1'b0, "post_rst_pop");
        check("post_rst_first", {20'd0, data_rx_o}, 32'h9A1);
        step(1'b0, 12'h000, 1'b1, 1'b0, "post_rst_pop");

        write_enable_rx_i = 1'b0;
        read_enable_rx_i  = 1'b0;
        clear_i           = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
